subtrator_serial_ctrl: RTL and testbench

SUBTRATOR_SERIAL_CTRL -- requirements
Module: subtrator_serial_ctrl

---
 rtl/subtrator_serial_ctrl.sv | 118 +++++++++++
 tb/tb_subtrator_serial_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/subtrator_serial_ctrl.sv
// Bit-serial unsigned subtractor A-B with valid/ready handshakes on both sides.
// Latency: out_valid rises WIDTH cycles after the accept edge; one op in flight.
// Backpressure: result is held in DONE until out_ready; in_ready only in IDLE.
//
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid/in_ready, a, b : operand pair handshake (unsigned minuend/subtrahend)
//   out_valid/out_ready   : result handshake
//   diff, borrow_out      : A-B mod 2^WIDTH and final borrow (1 when A<B)
//   busy                  : high while bits are being shifted through
module subtrator_serial_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             br_q;
    logic [CW-1:0]    cnt_q;

    logic             half_d;
    logic             d_bit;
    logic             br_next;
    logic             last_bit;
    logic [WIDTH-1:0] res_next;

    // Full subtractor built from two half-subtractor stages:
    // stage 1 computes a^b, stage 2 folds in the incoming borrow.
    assign half_d   = a_sh[0] ^ b_sh[0];
    assign d_bit    = half_d ^ br_q;
    assign br_next  = (~a_sh[0] & b_sh[0]) | (~half_d & br_q);
    assign last_bit = (cnt_q == CW'(WIDTH - 1));
    // Result bits enter at the MSB so bit i ends up in position i after WIDTH shifts.
    assign res_next = {d_bit, res_sh[WIDTH-1:1]};

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == SHIFT);
    assign out_valid = (state_q == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = SHIFT;
            SHIFT:   if (last_bit) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh       <= '0;
            b_sh       <= '0;
            res_sh     <= '0;
            br_q       <= 1'b0;
            cnt_q      <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        br_q  <= 1'b0;
                        cnt_q <= '0;
                    end
                end
                SHIFT: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res_sh <= res_next;
                    br_q   <= br_next;
                    // The output register only moves on the MSB edge, so diff
                    // and borrow_out stay frozen through SHIFT, DONE and IDLE.
                    if (last_bit) begin
                        diff       <= res_next;
                        borrow_out <= br_next;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_subtrator_serial_ctrl.sv
module tb_subtrator_serial_ctrl;

    typedef struct {
        logic [7:0] d;
        logic       br;
        int         acc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    // WIDTH=8 instance
    logic       in_valid8 = 1'b0;
    logic       in_ready8;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       out_valid8;
    logic       out_ready8 = 1'b1;
    logic [7:0] diff8;
    logic       borrow8;
    logic       busy8;

    // WIDTH=2 instance
    logic       in_valid2 = 1'b0;
    logic       in_ready2;
    logic [1:0] a2 = '0;
    logic [1:0] b2 = '0;
    logic       out_valid2;
    logic       out_ready2 = 1'b1;
    logic [1:0] diff2;
    logic       borrow2;
    logic       busy2;

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   rdy_mode = 0;   // 0: out_ready high, 1: random, 2: driven by test
    exp_t q8[$];
    exp_t q2[$];
    logic [7:0] last_hs_d = '0;
    logic       last_hs_br = 1'b0;
    int   ops_done8 = 0;

    subtrator_serial_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(out_ready8),
        .diff(diff8), .borrow_out(borrow8), .busy(busy8)
    );

    subtrator_serial_ctrl #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .a(a2), .b(b2), .out_valid(out_valid2), .out_ready(out_ready2),
        .diff(diff2), .borrow_out(borrow2), .busy(busy2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    always @(posedge clk) begin
        #1;
        if (rdy_mode == 1) out_ready8 = 1'($urandom_range(0, 1));
        else if (rdy_mode == 0) out_ready8 = 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain unsigned arithmetic.
    function automatic exp_t model(input int av, input int bv, input int w, input int acc);
        exp_t e;
        int   m;
        m    = 1 << w;
        e.d  = 8'(((av - bv) % m + m) % m);
        e.br = (av < bv);
        e.acc = acc;
        return e;
    endfunction

    // ---------------- WIDTH=8 observer / scoreboard monitor ----------------
    logic       prev_vld8 = 1'b0;
    logic       prev_hs8 = 1'b0;
    logic [8:0] last_out8 = '0;
    int         busy_cnt8 = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_hs8) begin
                chk("in_ready_after_handoff", 32'(in_ready8), 32'd1);
                chk("out_valid_after_handoff", 32'(out_valid8), 32'd0);
            end
            if (busy8 || (out_valid8 && prev_vld8))
                chk("out_stable", 32'({borrow8, diff8}), 32'(last_out8));
            if (out_valid8 && !prev_vld8) begin
                if (q8.size() == 0) begin
                    chk("unexpected_out_valid8", 32'(out_valid8), 32'd0);
                end else begin
                    chk("latency8", 32'(cyc - q8[0].acc), 32'd8);
                    chk("busy_cycles8", 32'(busy_cnt8), 32'd8);
                end
            end
            if (out_valid8) chk("in_ready_low_in_done", 32'(in_ready8 | busy8), 32'd0);
            prev_hs8 = 1'b0;
            if (out_valid8 && out_ready8 && q8.size() != 0) begin
                exp_t e;
                e = q8.pop_front();
                chk("diff8", 32'(diff8), 32'(e.d));
                chk("borrow8", 32'(borrow8), 32'(e.br));
                last_hs_d  = diff8;
                last_hs_br = borrow8;
                ops_done8++;
                prev_hs8 = 1'b1;
            end
            if (busy8) busy_cnt8++;
            if (in_valid8 && in_ready8) begin
                q8.push_back(model(int'(a8), int'(b8), 8, cyc + 1));
                busy_cnt8 = 0;
            end
            prev_vld8 = out_valid8;
            last_out8 = {borrow8, diff8};
        end else begin
            prev_vld8 = 1'b0;
            prev_hs8  = 1'b0;
        end
    end

    // ---------------- WIDTH=2 observer / scoreboard monitor ----------------
    logic prev_vld2 = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid2 && !prev_vld2) begin
                if (q2.size() == 0) chk("unexpected_out_valid2", 32'(out_valid2), 32'd0);
                else chk("latency2", 32'(cyc - q2[0].acc), 32'd2);
            end
            if (out_valid2 && out_ready2) begin
                if (q2.size() == 0) begin
                    chk("unexpected_hs2", 32'(out_valid2), 32'd0);
                end else begin
                    exp_t e;
                    e = q2.pop_front();
                    chk("diff2", 32'(diff2), 32'(e.d[1:0]));
                    chk("borrow2", 32'(borrow2), 32'(e.br));
                end
            end
            if (in_valid2 && in_ready2) q2.push_back(model(int'(a2), int'(b2), 2, cyc + 1));
            prev_vld2 = out_valid2;
        end else begin
            prev_vld2 = 1'b0;
        end
    end

    // Present a pair and hold it until accepted; afterwards scramble a/b.
    task automatic issue8(input logic [7:0] av, input logic [7:0] bv);
        int t;
        t = 0;
        a8 = av;
        b8 = bv;
        in_valid8 = 1'b1;
        do begin
            @(negedge clk);
            t++;
        end while (!in_ready8 && t < 200);
        if (!in_ready8) chk("accept_timeout8", 32'(in_ready8), 32'd1);
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
        a8 = 8'($urandom);
        b8 = 8'($urandom);
    endtask

    task automatic drain8();
        int t;
        t = 0;
        while (q8.size() != 0 && t < 400) begin
            @(posedge clk);
            t++;
        end
        if (q8.size() != 0) chk("drain_timeout8", 32'(q8.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset values
        #2;
        chk("rst_in_ready", 32'(in_ready8), 32'd1);
        chk("rst_busy", 32'(busy8), 32'd0);
        chk("rst_out_valid", 32'(out_valid8), 32'd0);
        chk("rst_diff", 32'(diff8), 32'd0);
        chk("rst_borrow", 32'(borrow8), 32'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed cases
        issue8(8'h5A, 8'h3C);
        drain8();
        chk("dir_5A_3C_diff", 32'(last_hs_d), 32'h1E);
        chk("dir_5A_3C_borrow", 32'(last_hs_br), 32'd0);
        issue8(8'h00, 8'h01);
        issue8(8'h80, 8'h80);
        issue8(8'hFF, 8'h00);
        drain8();

        // Hold result in DONE for 5 cycles with ignored in_valid pulses
        rdy_mode = 2;
        out_ready8 = 1'b0;
        issue8(8'hA5, 8'h5B);
        begin
            int t;
            t = 0;
            while (!out_valid8 && t < 50) begin
                @(posedge clk);
                #1;
                t++;
            end
            chk("hold_reached_done", 32'(out_valid8), 32'd1);
        end
        repeat (5) begin
            @(posedge clk);
            #1;
            in_valid8 = 1'($urandom_range(0, 1));
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            chk("hold_out_valid", 32'(out_valid8), 32'd1);
        end
        in_valid8 = 1'b0;
        out_ready8 = 1'b1;
        rdy_mode = 0;
        drain8();

        // Reset in the middle of an operation
        issue8(8'h77, 8'h11);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", 32'(in_ready8), 32'd1);
        chk("midrst_busy", 32'(busy8), 32'd0);
        chk("midrst_out_valid", 32'(out_valid8), 32'd0);
        chk("midrst_outs", 32'({borrow8, diff8}), 32'd0);
        q8.delete();
        #1;
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("midrst_no_out_valid", 32'(out_valid8), 32'd0);
        issue8(8'h10, 8'h20);
        drain8();
        chk("post_rst_diff", 32'(last_hs_d), 32'hF0);
        chk("post_rst_borrow", 32'(last_hs_br), 32'd1);

        // Random regression with random out_ready
        rdy_mode = 1;
        for (int i = 0; i < 1000; i++) issue8(8'($urandom), 8'($urandom));
        drain8();
        rdy_mode = 0;
        chk("ops_completed8", 32'(ops_done8), 32'd1006);

        // WIDTH=2 exhaustive
        for (int i = 0; i < 16; i++) begin
            int t;
            t = 0;
            a2 = 2'(i >> 2);
            b2 = 2'(i);
            in_valid2 = 1'b1;
            do begin
                @(negedge clk);
                t++;
            end while (!in_ready2 && t < 50);
            if (!in_ready2) chk("accept_timeout2", 32'(in_ready2), 32'd1);
            @(posedge clk);
            #1;
            in_valid2 = 1'b0;
            a2 = 2'($urandom);
            b2 = 2'($urandom);
        end
        begin
            int t;
            t = 0;
            while (q2.size() != 0 && t < 50) begin
                @(posedge clk);
                t++;
            end
            chk("drain2", 32'(q2.size()), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
